// File: rtl/led_port_ctrl_if.sv
// Register write bus for led_port_ctrl: a one-cycle write strobe with
// a 2-bit register address and N_LED-bit data.
interface led_port_ctrl_if #(
  parameter int unsigned N_LED = 8
) ();
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [N_LED-1:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/led_port_ctrl.sv
// LED output-port controller: CPU-written DATA/MODE/DUTY registers drive N_LED
// registered LEDs in direct, blink, PWM-dimmed or rotating-chase mode.
module led_port_ctrl #(
  parameter int unsigned N_LED     = 8,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic              clk25m,
  input  logic              rst_n,
  led_port_ctrl_if.slave    wr_bus,
  output logic [N_LED-1:0]  led,
  output logic              tick
);

  localparam int unsigned PrescW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PrescW-1:0]   PrescLast = PrescW'(BLINK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PwmLast   = PWM_BITS'((1 << PWM_BITS) - 2);

  typedef enum logic [1:0] {
    ModeDirect = 2'd0,
    ModeBlink  = 2'd1,
    ModePwm    = 2'd2,
    ModeChase  = 2'd3
  } mode_e;

  logic [N_LED-1:0]    data_q, data_d;
  mode_e               mode_q, mode_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_LED-1:0]    chase_q, chase_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic                tick_q, tick_d;
  logic                blink_phase_q, blink_phase_d;

  logic data_wr, mode_wr, duty_wr;
  logic wrap, pwm_on;

  assign data_wr = wr_bus.wr_en && (wr_bus.wr_addr == 2'd0);
  assign mode_wr = wr_bus.wr_en && (wr_bus.wr_addr == 2'd1);
  assign duty_wr = wr_bus.wr_en && (wr_bus.wr_addr == 2'd2);
  assign wrap    = (presc_q == PrescLast);
  assign pwm_on  = (pwm_cnt_q < duty_q);

  always_comb begin
    data_d        = data_q;
    mode_d        = mode_q;
    duty_d        = duty_q;
    presc_d       = presc_q + PrescW'(1);
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    chase_d       = chase_q;
    blink_phase_d = blink_phase_q;
    tick_d        = 1'b0;
    led_d         = '0;

    if (data_wr) data_d = wr_bus.wr_data;
    if (mode_wr) mode_d = mode_e'(wr_bus.wr_data[1:0]);
    if (duty_wr) duty_d = wr_bus.wr_data[PWM_BITS-1:0];

    if (pwm_cnt_q == PwmLast) pwm_cnt_d = '0;

    // A MODE write restarts the blink/chase timebase and swallows a coincident tick.
    if (mode_wr) begin
      presc_d       = '0;
      blink_phase_d = 1'b1;
    end else if (wrap) begin
      presc_d       = '0;
      blink_phase_d = ~blink_phase_q;
      tick_d        = 1'b1;
    end

    // DATA load beats a same-cycle rotate.
    if (data_wr) begin
      chase_d = wr_bus.wr_data;
    end else if (mode_wr) begin
      chase_d = data_q;
    end else if (wrap && (mode_q == ModeChase)) begin
      chase_d = {chase_q[N_LED-2:0], chase_q[N_LED-1]};
    end

    unique case (mode_q)
      ModeDirect: led_d = data_q;
      ModeBlink:  led_d = blink_phase_q ? data_q : '0;
      ModePwm:    led_d = pwm_on ? data_q : '0;
      ModeChase:  led_d = chase_q;
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      data_q        <= '0;
      mode_q        <= ModeDirect;
      duty_q        <= '0;
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      chase_q       <= '0;
      led_q         <= '0;
      tick_q        <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      data_q        <= data_d;
      mode_q        <= mode_d;
      duty_q        <= duty_d;
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      chase_q       <= chase_d;
      led_q         <= led_d;
      tick_q        <= tick_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_port_ctrl.sv
// Directed bench for led_port_ctrl with N_LED=8, PWM_BITS=2, BLINK_DIV=4.
module tb_led_port_ctrl;

  logic       clk25m;
  logic       rst_n;
  logic [7:0] led;
  logic       tick;
  int         checks;
  int         errors;
  int unsigned edge_cnt;

  led_port_ctrl_if #(.N_LED(8)) wr_if ();

  led_port_ctrl #(
    .N_LED    (8),
    .PWM_BITS (2),
    .BLINK_DIV(4)
  ) dut (
    .clk25m(clk25m),
    .rst_n (rst_n),
    .wr_bus(wr_if.slave),
    .led   (led),
    .tick  (tick)
  );

  initial begin
    clk25m = 1'b0;
    forever #5 clk25m = ~clk25m;
  end

  // Edges since reset release; PWM counter after edge e equals e mod 3.
  always @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic step();
    @(posedge clk25m);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_addr = addr;
    wr_if.wr_data = data;
    step();
    wr_if.wr_en   = 1'b0;
    wr_if.wr_addr = 2'd0;
    wr_if.wr_data = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL reset_led: got %h want 00", led);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick: got %b want 0", tick);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (tick !== ((i % 4) == 0)) begin
        errors++;
        $display("FAIL idle_tick[%0d]: got %b want %b", i, tick, (i % 4) == 0);
      end
      checks++;
      if (led !== 8'h00) begin
        errors++;
        $display("FAIL idle_led[%0d]: got %h want 00", i, led);
      end
    end
  endtask

  task automatic test_direct();
    wr(2'd0, 8'hA5);
    step();
    checks++;
    if (led !== 8'hA5) begin
      errors++;
      $display("FAIL direct: got %h want a5", led);
    end
    wr(2'd3, 8'hFF);
    step();
    checks++;
    if (led !== 8'hA5) begin
      errors++;
      $display("FAIL reserved_write: got %h want a5", led);
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'h01);
    for (int i = 1; i <= 9; i++) begin
      step();
      exp = (i <= 4 || i == 9) ? 8'hFF : 8'h00;
      checks++;
      if (led !== exp) begin
        errors++;
        $display("FAIL blink[%0d]: got %h want %h", i, led, exp);
      end
    end
  endtask

  task automatic test_mode_mid_blink();
    logic [7:0] exp;
    wr(2'd1, 8'h01);
    for (int i = 1; i <= 5; i++) step();
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL mid_blink_off: got %h want 00", led);
    end
    wr(2'd1, 8'h01);
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL mid_blink_wr_edge: got %h want 00", led);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = (i <= 4) ? 8'hFF : 8'h00;
      checks++;
      if (led !== exp) begin
        errors++;
        $display("FAIL mid_blink_restart[%0d]: got %h want %h", i, led, exp);
      end
    end
  endtask

  task automatic test_pwm();
    logic [7:0] exp;
    int unsigned duty;
    wr(2'd0, 8'h3C);
    wr(2'd1, 8'h02);
    for (int d = 0; d < 3; d++) begin
      duty = (d == 0) ? 1 : (d == 1) ? 0 : 3;
      wr(2'd2, duty[7:0]);
      for (int i = 0; i < 6; i++) begin
        step();
        exp = (((edge_cnt - 1) % 3) < duty) ? 8'h3C : 8'h00;
        checks++;
        if (led !== exp) begin
          errors++;
          $display("FAIL pwm_duty%0d[%0d]: got %h want %h", duty, i, led, exp);
        end
      end
    end
  endtask

  task automatic test_chase();
    logic [7:0] exp;
    wr(2'd0, 8'h80);
    wr(2'd1, 8'h03);
    for (int i = 1; i <= 11; i++) begin
      step();
      exp = (i <= 4) ? 8'h80 : (i <= 8) ? 8'h01 : 8'h02;
      checks++;
      if (led !== exp) begin
        errors++;
        $display("FAIL chase[%0d]: got %h want %h", i, led, exp);
      end
    end
    wr(2'd0, 8'h81);
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL chase_tick: got %b want 1", tick);
    end
    checks++;
    if (led !== 8'h02) begin
      errors++;
      $display("FAIL chase_load_edge: got %h want 02", led);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = (i <= 4) ? 8'h81 : 8'h03;
      checks++;
      if (led !== exp) begin
        errors++;
        $display("FAIL chase_load[%0d]: got %h want %h", i, led, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'h01);
    step();
    checks++;
    if (led !== 8'hFF) begin
      errors++;
      $display("FAIL pre_reset_led: got %h want ff", led);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_led: got %h want 00", led);
    end
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (led !== 8'h00) begin
        errors++;
        $display("FAIL post_reset_led[%0d]: got %h want 00", i, led);
      end
      checks++;
      if (tick !== ((i % 4) == 0)) begin
        errors++;
        $display("FAIL post_reset_tick[%0d]: got %b want %b", i, tick, (i % 4) == 0);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_addr = 2'd0;
    wr_if.wr_data = 8'h00;
    test_reset();
    test_direct();
    test_blink();
    test_mode_mid_blink();
    test_pwm();
    test_chase();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
